// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: mult/div sequencer state and default latency.
package pipe_ctrl_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MD_LATENCY_DEF = 32;
endpackage

// File: rtl/stall_ctrl_if.sv
// Hazard inputs from issue/EX and stall/flush/mult-div controls back to the pipeline.
interface stall_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic [4:0]             rs_iss_i;
  logic [4:0]             rt_iss_i;
  logic [4:0]             rt_ex_i;
  logic                   mem_to_reg_ex_i;
  logic                   reg_wr_ex_i;
  logic                   branch_taken_ex_i;
  logic                   md_start_iss_i;
  logic                   md_use_iss_i;
  logic                   stall_fetch_o;
  logic                   stall_iss_o;
  logic                   flush_ex_o;
  logic                   flush_iss_o;
  logic                   md_go_o;
  logic                   md_busy_o;
  logic                   md_done_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;

  modport master (
    output rs_iss_i, rt_iss_i, rt_ex_i, mem_to_reg_ex_i, reg_wr_ex_i,
           branch_taken_ex_i, md_start_iss_i, md_use_iss_i,
    input  stall_fetch_o, stall_iss_o, flush_ex_o, flush_iss_o,
           md_go_o, md_busy_o, md_done_o, stall_cnt_o
  );

  modport slave (
    input  rs_iss_i, rt_iss_i, rt_ex_i, mem_to_reg_ex_i, reg_wr_ex_i,
           branch_taken_ex_i, md_start_iss_i, md_use_iss_i,
    output stall_fetch_o, stall_iss_o, flush_ex_o, flush_iss_o,
           md_go_o, md_busy_o, md_done_o, stall_cnt_o
  );
endinterface

// File: rtl/md_seq.sv
// Mult/div occupancy sequencer: IDLE/BUSY FSM with a down-counter over MD_LATENCY cycles.
module md_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic md_go_o,
  output logic md_busy_o,
  output logic md_done_o
);
  localparam int unsigned     CNT_W    = $clog2(MD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_go_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          md_go_o = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign md_busy_o = (state_q == BUSY);
  assign md_done_o = (state_q == BUSY) && (cnt_q == '0);
endmodule

// File: rtl/stall_ctrl.sv
// Stall/flush sequencer: load-use and HI/LO hazards stall issue; taken branches squash issue.
module stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY  = MD_LATENCY_DEF,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  stall_ctrl_if.slave  bus
);
  logic lu, mh, redirect, hazard, md_start_ok;
  logic md_go, md_busy, md_done;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign lu = bus.mem_to_reg_ex_i & bus.reg_wr_ex_i & (|bus.rt_ex_i) &
              ((bus.rt_ex_i == bus.rs_iss_i) | (bus.rt_ex_i == bus.rt_iss_i));
  assign mh       = md_busy & (bus.md_use_iss_i | bus.md_start_iss_i);
  assign redirect = bus.branch_taken_ex_i;

  // Combinational outputs are gated by rst so everything reads 0 while in reset.
  assign hazard      = !rst & !redirect & (lu | mh);
  assign md_start_ok = !rst & !redirect & !lu & bus.md_start_iss_i;

  md_seq #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_seq (
    .clk       (clk),
    .rst       (rst),
    .start_i   (md_start_ok),
    .md_go_o   (md_go),
    .md_busy_o (md_busy),
    .md_done_o (md_done)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_fetch_o = hazard;
  assign bus.stall_iss_o   = hazard;
  assign bus.flush_ex_o    = hazard;
  assign bus.flush_iss_o   = !rst & redirect;
  assign bus.md_go_o       = md_go;
  assign bus.md_busy_o     = md_busy;
  assign bus.md_done_o     = md_done;
  assign bus.stall_cnt_o   = stall_cnt_q;
endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_stall_ctrl;
  localparam int unsigned LAT = 4;
  localparam int unsigned SW  = 4;
  localparam int          SAT = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stall_ctrl_if #(.STALL_CNT_W(SW)) bus ();

  stall_ctrl #(
    .MD_LATENCY (LAT),
    .STALL_CNT_W(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: remaining busy cycles of the mult/div unit and the stall count.
  int rem  = 0;
  int scnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit lu, mh, br, e_stall, e_go;
    if (rst) begin
      chk("rst_outs", int'({bus.stall_fetch_o, bus.stall_iss_o, bus.flush_ex_o, bus.flush_iss_o,
                            bus.md_go_o, bus.md_busy_o, bus.md_done_o}), 0);
      chk("rst_cnt", int'(bus.stall_cnt_o), 0);
      rem  = 0;
      scnt = 0;
    end else begin
      br = bus.branch_taken_ex_i;
      lu = bus.mem_to_reg_ex_i && bus.reg_wr_ex_i && (bus.rt_ex_i != 0) &&
           (bus.rt_ex_i == bus.rs_iss_i || bus.rt_ex_i == bus.rt_iss_i);
      mh = (rem > 0) && (bus.md_use_iss_i || bus.md_start_iss_i);
      e_stall = !br && (lu || mh);
      e_go    = !br && !lu && bus.md_start_iss_i && (rem == 0);
      chk("stall_fetch", int'(bus.stall_fetch_o), int'(e_stall));
      chk("stall_iss",   int'(bus.stall_iss_o),   int'(e_stall));
      chk("flush_ex",    int'(bus.flush_ex_o),    int'(e_stall));
      chk("flush_iss",   int'(bus.flush_iss_o),   int'(br));
      chk("md_go",       int'(bus.md_go_o),       int'(e_go));
      chk("md_busy",     int'(bus.md_busy_o),     int'(rem > 0));
      chk("md_done",     int'(bus.md_done_o),     int'(rem == 1));
      chk("stall_cnt",   int'(bus.stall_cnt_o),   scnt);
      if (e_stall && scnt < SAT) scnt = scnt + 1;
      if (e_go)         rem = LAT;
      else if (rem > 0) rem = rem - 1;
    end
  end

  task automatic idle_inputs();
    bus.rs_iss_i          = '0;
    bus.rt_iss_i          = '0;
    bus.rt_ex_i           = '0;
    bus.mem_to_reg_ex_i   = 1'b0;
    bus.reg_wr_ex_i       = 1'b0;
    bus.branch_taken_ex_i = 1'b0;
    bus.md_start_iss_i    = 1'b0;
    bus.md_use_iss_i      = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use(input logic [4:0] r);
    bus.rt_ex_i         = r;
    bus.rs_iss_i        = r;
    bus.mem_to_reg_ex_i = 1'b1;
    bus.reg_wr_ex_i     = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    do_reset();
    step();

    // Load-use stall for one cycle, counted once
    load_use(5'd5);
    #2;
    chk("lu_stall", int'(bus.stall_iss_o), 1);
    chk("lu_flush_ex", int'(bus.flush_ex_o), 1);
    step();
    idle_inputs();
    #2;
    chk("lu_release", int'(bus.stall_iss_o), 0);
    chk("lu_cnt", int'(bus.stall_cnt_o), 1);
    step();
    load_use(5'd0);
    #2;
    chk("lu_r0_nostall", int'(bus.stall_iss_o), 0);
    step();
    idle_inputs();

    // MD launch, followed by MFHI held in issue
    bus.md_start_iss_i = 1'b1;
    #2;
    chk("md_go_launch", int'(bus.md_go_o), 1);
    chk("md_busy_launch", int'(bus.md_busy_o), 0);
    for (int unsigned i = 1; i <= LAT; i++) begin
      step();
      bus.md_start_iss_i = 1'b0;
      bus.md_use_iss_i   = 1'b1;
      #2;
      chk("md_busy_n", int'(bus.md_busy_o), 1);
      chk("mfhi_stall", int'(bus.stall_iss_o), 1);
      chk("md_done_n", int'(bus.md_done_o), int'(i == LAT));
      chk("md_go_n", int'(bus.md_go_o), 0);
    end
    step();
    #2;
    chk("md_busy_end", int'(bus.md_busy_o), 0);
    chk("mfhi_release", int'(bus.stall_iss_o), 0);
    chk("mfhi_cnt", int'(bus.stall_cnt_o), 1 + LAT);
    step();
    idle_inputs();

    // Branch priority over load-use and launch
    load_use(5'd7);
    bus.branch_taken_ex_i = 1'b1;
    bus.md_start_iss_i    = 1'b1;
    #2;
    chk("br_flush_iss", int'(bus.flush_iss_o), 1);
    chk("br_stalls", int'({bus.stall_fetch_o, bus.stall_iss_o, bus.flush_ex_o}), 0);
    chk("br_no_go", int'(bus.md_go_o), 0);
    step();
    idle_inputs();
    #2;
    chk("br_idle", int'(bus.md_busy_o), 0);

    // Reset in the middle of BUSY
    step();
    bus.md_start_iss_i = 1'b1;
    step();
    bus.md_start_iss_i = 1'b0;
    step();
    #2;
    chk("pre_rst_busy", int'(bus.md_busy_o), 1);
    rst = 1'b1;
    #1;
    chk("rst_abort_busy", int'(bus.md_busy_o), 0);
    chk("rst_abort_done", int'(bus.md_done_o), 0);
    step();
    rst = 1'b0;
    step();
    bus.md_start_iss_i = 1'b1;
    #2;
    chk("post_rst_go", int'(bus.md_go_o), 1);
    for (int unsigned i = 1; i <= LAT + 1; i++) begin
      step();
      bus.md_start_iss_i = 1'b0;
      #2;
      chk("post_rst_busy", int'(bus.md_busy_o), int'(i <= LAT));
      chk("post_rst_done", int'(bus.md_done_o), int'(i == LAT));
    end

    // Saturation of the stall counter
    do_reset();
    load_use(5'd9);
    repeat (20) step();
    idle_inputs();
    #2;
    chk("cnt_saturate", int'(bus.stall_cnt_o), SAT);

    // Randomized traffic; the per-cycle model checks every cycle
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      step();
      rst                   = ($urandom_range(0, 299) == 0);
      bus.rs_iss_i          = 5'($urandom_range(0, 3));
      bus.rt_iss_i          = 5'($urandom_range(0, 3));
      bus.rt_ex_i           = 5'($urandom_range(0, 3));
      bus.mem_to_reg_ex_i   = ($urandom_range(0, 2) == 0);
      bus.reg_wr_ex_i       = ($urandom_range(0, 3) != 0);
      bus.branch_taken_ex_i = ($urandom_range(0, 7) == 0);
      bus.md_start_iss_i    = ($urandom_range(0, 4) == 0);
      bus.md_use_iss_i      = ($urandom_range(0, 4) == 0);
      if (n % 500 == 0) do_reset();
    end
    step();
    idle_inputs();
    rst = 1'b0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
